// File: rtl/ascon_output_collector.sv
// Pulls ciphertext and tag bytes out of the Ascon wrapper's byte-serial port and
// re-emits them as a valid/ready byte stream, then wraps the wrapper's output counter.
module ascon_output_collector #(
    parameter int unsigned Y     = 16,
    parameter int unsigned TAG   = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       encryption_readyxSI,
    output logic       reg_outxSS,
    input  logic [7:0] cipher_tagxSI,
    output logic [7:0] m_dataxDO,
    output logic       m_validxSO,
    input  logic       m_readyxSI,
    output logic       m_lastxSO,
    output logic       m_tagxSO,
    output logic       busyxSO,
    output logic       donexSO,
    output logic       abortxSO
);
    localparam int unsigned N   = (Y + TAG) / 8;
    localparam int unsigned YB  = Y / 8;
    localparam int unsigned CW  = $clog2(N + 1);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned OW  = $clog2(DEPTH + 1);
    localparam int unsigned OW1 = OW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, WRAP, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] req, req_n, cap, cap_n, idx, idx_n;
    logic [OW-1:0] occ, occ_n;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [7:0]    mem [DEPTH];
    logic          fetch_d, wrap_sent, wrap_n, strobe_n;
    logic          active, abort_c, push, pop, fetch_now, wrap_now;

    assign m_dataxDO  = mem[rd_ptr];
    assign m_validxSO = (occ != '0);
    assign m_tagxSO   = m_validxSO && (idx >= CW'(YB));
    assign m_lastxSO  = m_validxSO && (idx == CW'(N - 1));

    // Next-state and counter bookkeeping; the strobe is decided one cycle ahead
    // from the next-cycle occupancy so reg_outxSS can come straight from a flop.
    always_comb begin
        active    = (state == FETCH) || (state == WRAP);
        abort_c   = active && !encryption_readyxSI;
        pop       = m_validxSO && m_readyxSI;
        push      = active && fetch_d;
        fetch_now = reg_outxSS && (state == FETCH);
        wrap_now  = reg_outxSS && (state == WRAP);

        state_n = state;
        req_n   = req;
        cap_n   = cap;
        idx_n   = idx;
        occ_n   = occ;
        wrap_n  = wrap_sent;

        if (active) begin
            req_n  = req + CW'(fetch_now);
            cap_n  = cap + CW'(push);
            idx_n  = idx + CW'(pop);
            occ_n  = occ + OW'(push) - OW'(pop);
            wrap_n = wrap_sent | wrap_now;
        end

        case (state)
            IDLE: begin
                if (encryption_readyxSI) begin
                    state_n = FETCH;
                    req_n   = '0;
                    cap_n   = '0;
                    idx_n   = '0;
                    occ_n   = '0;
                    wrap_n  = 1'b0;
                end
            end
            FETCH: begin
                if (abort_c) begin
                    state_n = IDLE;
                    occ_n   = '0;
                end else if (req_n == CW'(N)) begin
                    state_n = WRAP;
                end
            end
            WRAP: begin
                if (abort_c) begin
                    state_n = IDLE;
                    occ_n   = '0;
                end else if (wrap_n && (idx_n == CW'(N))) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!encryption_readyxSI) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        strobe_n = ((state_n == FETCH) && (req_n < CW'(N)) &&
                    ((OW1'(occ_n) + OW1'(fetch_now)) < OW1'(DEPTH))) ||
                   ((state_n == WRAP) && (cap_n == CW'(N)) && !wrap_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req        <= '0;
            cap        <= '0;
            idx        <= '0;
            occ        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fetch_d    <= 1'b0;
            wrap_sent  <= 1'b0;
            reg_outxSS <= 1'b0;
            busyxSO    <= 1'b0;
            donexSO    <= 1'b0;
            abortxSO   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state      <= state_n;
            req        <= req_n;
            cap        <= cap_n;
            idx        <= idx_n;
            occ        <= occ_n;
            wrap_sent  <= wrap_n;
            reg_outxSS <= strobe_n;
            fetch_d    <= fetch_now && !abort_c;
            abortxSO   <= abort_c;
            busyxSO    <= (state_n == FETCH) || (state_n == WRAP);
            donexSO    <= (state_n == DONE);
            // Pointers restart from zero for every job; abort flush is via occ.
            if (state == IDLE) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= cipher_tagxSI;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end
endmodule
